// File: rtl/osd_cmd_tx.sv
// ---------------------------------------------------------------------------
// osd_cmd_tx
//
// Bus master for the OSD command interface. Takes one request at a time
// through a valid/ready handshake and serialises it as a framed sequence of
// strobed 16-bit words on io_osd/io_strobe/io_din. Write requests stream
// bytes from a synchronous character/bitmap RAM with a one-cycle read latency.
//
// Ports
//   clk_sys    : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : idle and accepting a request
//   req_op     : 0 disable, 1 enable, 2 enable + info window, 3 buffer write
//   req_bank   : write start block (bit 3 selects the highres bank)
//   req_len    : bytes to write, 0 means 256
//   req_x/y    : info window origin
//   req_w/h    : info window size in pixels (sent divided by 8)
//   buf_rd     : RAM read pulse
//   buf_addr   : RAM address {bank, byte index}
//   buf_data   : RAM data, valid the cycle after buf_rd
//   io_osd     : transaction frame
//   io_strobe  : word strobe, consumer samples on its rising edge
//   io_din     : word bus
//   done       : one-cycle pulse on the last gap cycle of a transaction
// ---------------------------------------------------------------------------
module osd_cmd_tx #(
    parameter int unsigned STB_HI = 2,
    parameter int unsigned STB_LO = 2,
    parameter int unsigned GAP    = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [3:0]  req_bank,
    input  logic [8:0]  req_len,
    input  logic [11:0] req_x,
    input  logic [11:0] req_y,
    input  logic [8:0]  req_w,
    input  logic [8:0]  req_h,
    output logic        buf_rd,
    output logic [11:0] buf_addr,
    input  logic [7:0]  buf_data,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        done
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] LO_LAST  = CW'(STB_LO - 1);
    localparam logic [CW-1:0] HI_LAST  = CW'(STB_HI - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0] GAP_PRE  = CW'(GAP - 2);

    localparam logic [1:0] OP_WRITE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_TAIL,
        ST_GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] phase_cnt;
    logic [8:0]    words_left;
    logic [7:0]    byte_idx;
    logic [1:0]    op_q;
    logic [3:0]    bank_q;
    logic [11:0]   x_q;
    logic [11:0]   y_q;
    logic [5:0]    w_q;
    logic [5:0]    h_q;

    logic [7:0]    cmd_byte;
    logic [8:0]    init_words_left;
    logic [15:0]   next_data;

    // Only the size in units of 8 pixels is transmitted.
    logic unused_size_bits;
    assign unused_size_bits = ^{req_w[2:0], req_h[2:0]};

    // Command byte and remaining-word count for the request on the bus.
    always_comb begin
        cmd_byte        = 8'h40;
        init_words_left = 9'd0;
        case (req_op)
            2'd0: begin
                cmd_byte        = 8'h40;
                init_words_left = 9'd0;
            end
            2'd1: begin
                cmd_byte        = 8'h41;
                init_words_left = 9'd0;
            end
            2'd2: begin
                cmd_byte        = 8'h45;
                init_words_left = 9'd4;
            end
            default: begin
                cmd_byte        = {4'h2, req_bank};
                init_words_left = (req_len == 9'd0) ? 9'd256 : req_len;
            end
        endcase
    end

    // Word that follows the one currently strobed. For info transactions the
    // remaining-word count identifies the field; writes take the prefetched
    // RAM byte, which is valid by the end of the HI phase.
    always_comb begin
        next_data = 16'h0000;
        if (op_q == OP_WRITE) begin
            next_data = {8'h00, buf_data};
        end else begin
            case (words_left)
                9'd4:    next_data = {4'h0, x_q};
                9'd3:    next_data = {4'h0, y_q};
                9'd2:    next_data = {10'h000, w_q};
                default: next_data = {10'h000, h_q};
            endcase
        end
    end

    // Transaction sequencer. Every output is registered; io_din only moves
    // on accept, on the strobe falling edge, and when the frame closes.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            words_left <= 9'd0;
            byte_idx   <= 8'd0;
            op_q       <= 2'd0;
            bank_q     <= 4'd0;
            x_q        <= 12'd0;
            y_q        <= 12'd0;
            w_q        <= 6'd0;
            h_q        <= 6'd0;
            req_ready  <= 1'b1;
            buf_rd     <= 1'b0;
            buf_addr   <= 12'd0;
            io_osd     <= 1'b0;
            io_strobe  <= 1'b0;
            io_din     <= 16'h0000;
            done       <= 1'b0;
        end else begin
            buf_rd <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        bank_q     <= req_bank;
                        x_q        <= req_x;
                        y_q        <= req_y;
                        w_q        <= req_w[8:3];
                        h_q        <= req_h[8:3];
                        words_left <= init_words_left;
                        byte_idx   <= 8'd0;
                        phase_cnt  <= '0;
                        req_ready  <= 1'b0;
                        io_osd     <= 1'b1;
                        io_din     <= {8'h00, cmd_byte};
                        state      <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (phase_cnt == LO_LAST) begin
                        phase_cnt <= '0;
                        io_strobe <= 1'b1;
                        state     <= ST_HI;
                        // Prefetch the byte for the next word; it lands on
                        // buf_data in time for the strobe falling edge.
                        if ((op_q == OP_WRITE) && (words_left != 9'd0)) begin
                            buf_rd   <= 1'b1;
                            buf_addr <= {bank_q, byte_idx};
                            byte_idx <= byte_idx + 8'd1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_HI: begin
                    if (phase_cnt == HI_LAST) begin
                        phase_cnt <= '0;
                        io_strobe <= 1'b0;
                        if (words_left == 9'd0) begin
                            state <= ST_TAIL;
                        end else begin
                            words_left <= words_left - 9'd1;
                            io_din     <= next_data;
                            state      <= ST_LO;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (phase_cnt == LO_LAST) begin
                        phase_cnt <= '0;
                        io_osd    <= 1'b0;
                        io_din    <= 16'h0000;
                        state     <= ST_GAP;
                        done      <= (GAP == 1);
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        phase_cnt <= '0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                        done      <= (phase_cnt == GAP_PRE);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
